// File: rtl/mean_seq_ctrl.sv
// Sequencer for the mean datapath: clears the accumulator, walks the ROM counter while
// accumulating, fires the divider on the final sum and captures the result after DIV_LAT.
//   state      | meaning
//   IDLE       | waiting for start
//   CLEAR      | accumulator clear, one cycle
//   ACCUM      | accumulate + count until counter carry-out
//   FLUSH      | aborted run; count to carry-out so the counter ends at 0
//   FLUSH_DONE | one-cycle done pulse after abort
//   WAIT       | divider latency countdown, then capture
module mean_seq_ctrl #(
  parameter int CNT_MAX = 255,
  parameter int DIV_LAT = 2,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         co,
  input  logic [W-1:0] mean_in,
  input  logic         zoz_in,
  output logic         enReg,
  output logic         cnten,
  output logic         clear,
  output logic         endiv,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] mean_out,
  output logic         zoz_out,
  output logic         err,
  output logic         aborted
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CLEAR      = 3'd1;
  localparam logic [2:0] S_ACCUM      = 3'd2;
  localparam logic [2:0] S_FLUSH      = 3'd3;
  localparam logic [2:0] S_FLUSH_DONE = 3'd4;
  localparam logic [2:0] S_WAIT       = 3'd5;

  localparam int              TW       = $clog2(CNT_MAX + 1) + 1;
  localparam logic [TW-1:0]   TO_LAST  = TW'(CNT_MAX);
  localparam logic [TW-1:0]   TO_ONE   = TW'(1);
  localparam logic [3:0]      LAT_LOAD = 4'(DIV_LAT - 1);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    lat_q, lat_d;
  logic          done_q, done_d;
  logic [W-1:0]  mean_q, mean_d;
  logic          zoz_q, zoz_d;
  logic          err_q, err_d;
  logic          aborted_q, aborted_d;

  // The timeout counter keeps running across ACCUM and FLUSH: an aligned run spends
  // exactly CNT_MAX+1 cycles in the two states together, whatever the abort point.
  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    lat_d     = lat_q;
    done_d    = 1'b0;
    mean_d    = mean_q;
    zoz_d     = zoz_q;
    err_d     = err_q;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLEAR;
          err_d     = 1'b0;
          aborted_d = 1'b0;
        end
      end
      S_CLEAR: begin
        to_d = '0;
        if (abort) begin
          state_d   = S_FLUSH_DONE;
          aborted_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        to_d = to_q + TO_ONE;
        if (co) begin
          state_d = S_WAIT;
          lat_d   = LAT_LOAD;
        end else if (abort) begin
          state_d   = S_FLUSH;
          aborted_d = 1'b1;
        end else if (to_q >= TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      S_FLUSH: begin
        to_d = to_q + TO_ONE;
        if (co) begin
          state_d = S_FLUSH_DONE;
          done_d  = 1'b1;
        end else if (to_q >= TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      S_FLUSH_DONE: begin
        state_d = S_IDLE;
      end
      S_WAIT: begin
        // abort beats a same-cycle capture; the counter already wrapped on entry
        if (abort) begin
          state_d   = S_FLUSH_DONE;
          aborted_d = 1'b1;
          done_d    = 1'b1;
        end else if (lat_q == 4'd0) begin
          state_d = S_IDLE;
          mean_d  = mean_in;
          zoz_d   = zoz_in;
          done_d  = 1'b1;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      to_q      <= '0;
      lat_q     <= '0;
      done_q    <= 1'b0;
      mean_q    <= '0;
      zoz_q     <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      lat_q     <= lat_d;
      done_q    <= done_d;
      mean_q    <= mean_d;
      zoz_q     <= zoz_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  assign enReg    = (state_q == S_ACCUM);
  assign cnten    = (state_q == S_ACCUM) || (state_q == S_FLUSH);
  assign clear    = (state_q == S_CLEAR);
  assign endiv    = (state_q == S_ACCUM) && co;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign mean_out = mean_q;
  assign zoz_out  = zoz_q;
  assign err      = err_q;
  assign aborted  = aborted_q;

endmodule
